// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings and framing constants.
package uart_program_loader_pkg;

  // 100 MHz system clock at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // The image header is a little-endian word count this many bytes long
  localparam int COUNT_BYTES = 2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_CNT_LO,
    L_CNT_HI,
    L_DATA,
    L_DONE,
    L_ERR
  } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop input synchroniser followed by the RX FSM.
// Emits a one-cycle byte_valid with byte_data, or a one-cycle frame_err when
// the stop bit is sampled low.
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  rx_state_t         state, state_d;
  logic              rx_p0, rx_p1;
  logic              rx_s;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              stop_wait;

  assign rx_s = rx_p1;

  // Synchronise the asynchronous line; idles high so reset to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rxd;
      rx_p1 <= rx_p0;
    end
  end

  // RX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_d;
  end

  // RX next-state: start detect, mid-start-bit glitch check, 8 data bits, stop bit
  always_comb begin
    state_d = state;
    case (state)
      RX_IDLE:  if (!rx_s) state_d = RX_START;
      RX_START: if (baud == HALF_LAST) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (baud == FULL_LAST && bit_cnt == 3'd7) state_d = RX_STOP;
      RX_STOP: begin
        // After a bad stop bit, hold here until the line recovers to idle
        if (stop_wait) begin
          if (rx_s) state_d = RX_IDLE;
        end else if (baud == FULL_LAST && rx_s) begin
          state_d = RX_IDLE;
        end
      end
      default:  state_d = RX_IDLE;
    endcase
  end

  // Baud/bit counters, shift register and the byte/error strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      stop_wait  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud      <= '0;
          bit_cnt   <= '0;
          stop_wait <= 1'b0;
        end
        RX_START: baud <= baud + 1'b1;
        RX_DATA: begin
          if (baud == FULL_LAST) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            baud    <= '0;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        RX_STOP: begin
          if (!stop_wait) begin
            if (baud == FULL_LAST) begin
              if (rx_s) begin
                byte_valid <= 1'b1;
                byte_data  <= shift;
              end else begin
                frame_err <= 1'b1;
                stop_wait <= 1'b1;
              end
              baud <= '0;
            end else begin
              baud <= baud + 1'b1;
            end
          end
        end
        default: baud <= '0;
      endcase
      // Every state entry starts a fresh baud interval
      if (state_d != state) baud <= '0;
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// UART program loader: receives a word-count header and a little-endian word
// stream, writes the words to memory and holds the cpu in reset until done.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NUM_OF_BYTES = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RxD,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_en,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int CNT_W     = 8 * COUNT_BYTES;
  localparam int MAX_WORDS = NUM_OF_BYTES / 4;

  ld_state_t        state, state_d;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             frame_err;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_full;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rxd       (RxD),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Header value as it stands once the high count byte arrives
  assign count_full = {byte_data, count[7:0]};

  // Loader state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= L_CNT_LO;
    else       state <= state_d;
  end

  // Loader next-state: header, data words, then terminal done/error
  always_comb begin
    state_d = state;
    case (state)
      L_CNT_LO: begin
        if (frame_err)       state_d = L_ERR;
        else if (byte_valid) state_d = L_CNT_HI;
      end
      L_CNT_HI: begin
        if (frame_err) state_d = L_ERR;
        else if (byte_valid) begin
          if (count_full == '0)                          state_d = L_DONE;
          else if (32'(count_full) > 32'(MAX_WORDS))     state_d = L_ERR;
          else                                           state_d = L_DATA;
        end
      end
      L_DATA: begin
        if (frame_err) state_d = L_ERR;
        else if (byte_valid && byte_idx == 2'd3 && word_idx + CNT_W'(1) == count)
          state_d = L_DONE;
      end
      L_DONE:  state_d = L_DONE;
      L_ERR:   state_d = L_ERR;
      default: state_d = L_ERR;
    endcase
  end

  // Header capture, word assembly, write strobe and sticky status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count          <= '0;
      word_idx       <= '0;
      byte_idx       <= '0;
      word_buf       <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write_en   <= 1'b0;
      cpu_hold       <= 1'b1;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      mem_write_en <= 1'b0;
      cpu_hold     <= (state_d != L_DONE);
      load_done    <= (state_d == L_DONE);
      load_error   <= (state_d == L_ERR);
      if (byte_valid) begin
        case (state)
          L_CNT_LO: count[7:0] <= byte_data;
          L_CNT_HI: begin
            count    <= count_full;
            word_idx <= '0;
            byte_idx <= '0;
          end
          L_DATA: begin
            case (byte_idx)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                mem_write_data <= {byte_data, word_buf};
                mem_address    <= 32'({word_idx, 2'b00});
                mem_write_en   <= 1'b1;
                word_idx       <= word_idx + CNT_W'(1);
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: directed and random images are
// serialised onto RxD, a reference model predicts the memory writes and final
// flags, and a monitor compares every write strobe against the expectation queue.
module tb_uart_program_loader;

  localparam int CPB   = 4;
  localparam int NBYTE = 16;
  localparam int MAXW  = NBYTE / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] bq[$];
  bit         sq[$];
  bit         exp_done, exp_err;
  int         checks = 0;
  int         errors = 0;
  logic       prev_en = 1'b0;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .NUM_OF_BYTES(NBYTE)) dut (
    .clk           (clk),
    .reset         (reset),
    .RxD           (rxd),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_write_en  (mem_write_en),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_error    (load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every write strobe is one cycle wide and matches the queue head
  always @(negedge clk) begin
    if (!reset && mem_write_en) begin
      checks++;
      if (prev_en) begin
        errors++;
        $display("FAIL write_width: strobe high for more than one cycle at addr %h", mem_address);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_address, mem_write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_address !== e.addr || mem_write_data !== e.data) begin
          errors++;
          $display("FAIL write: got %h <= %h expected %h <= %h",
                   mem_address, mem_write_data, e.addr, e.data);
        end
      end
    end
    prev_en <= reset ? 1'b0 : mem_write_en;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic [7:0] b, input bit ok);
    bq.push_back(b);
    sq.push_back(ok);
  endtask

  // Reference model: decide the outcome of the whole byte list from the loading rules
  task automatic model();
    int fe, n, words;
    fe = bq.size();
    for (int i = 0; i < bq.size(); i++) begin
      if (!sq[i]) begin fe = i; break; end
    end
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (fe < 2) begin
      exp_err = (fe < bq.size());
      return;
    end
    n = int'(bq[0]) + 256 * int'(bq[1]);
    if (n == 0) begin
      exp_done = 1'b1;
    end else if (n > MAXW) begin
      exp_err = 1'b1;
    end else begin
      words = (fe - 2) / 4;
      if (words > n) words = n;
      for (int w = 0; w < words; w++) begin
        wr_t e;
        e.addr = 32'(4 * w);
        e.data = {bq[2+4*w+3], bq[2+4*w+2], bq[2+4*w+1], bq[2+4*w]};
        exp_q.push_back(e);
      end
      if (words == n)          exp_done = 1'b1;
      else if (fe < bq.size()) exp_err  = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = ok;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_scenario(input string name, input bit do_reset);
    if (do_reset) pulse_reset();
    model();
    for (int i = 0; i < bq.size(); i++)
      send_byte(bq[i], sq[i], sq[i] ? int'($urandom_range(0, 3)) : 4);
    repeat (20) @(negedge clk);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_load_done"}, 32'(load_done), 32'(exp_done));
    chk({name, "_load_error"}, 32'(load_error), 32'(exp_err));
    chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    exp_q.delete();
    bq.delete();
    sq.delete();
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_addr"}, mem_address, 32'd0);
    chk({name, "_data"}, mem_write_data, 32'd0);
    chk({name, "_wen"}, 32'(mem_write_en), 32'd0);
    chk({name, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({name, "_done"}, 32'(load_done), 32'd0);
    chk({name, "_err"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Two-word image
    add(8'h02, 1); add(8'h00, 1);
    add(8'hEF, 1); add(8'hBE, 1); add(8'hAD, 1); add(8'hDE, 1);
    add(8'h78, 1); add(8'h56, 1); add(8'h34, 1); add(8'h12, 1);
    run_scenario("two_words", 1'b0);

    // Empty image, trailing byte ignored
    add(8'h00, 1); add(8'h00, 1); add(8'h55, 1);
    run_scenario("empty", 1'b1);

    // Oversize image
    add(8'h05, 1); add(8'h00, 1);
    for (int i = 0; i < 8; i++) add(8'($urandom), 1);
    run_scenario("oversize", 1'b1);

    // Framing error mid-word, then a clean reload
    add(8'h01, 1); add(8'h00, 1); add(8'hAA, 1); add(8'h5C, 0);
    add(8'h77, 1);
    run_scenario("frame_err", 1'b1);
    add(8'h01, 1); add(8'h00, 1);
    add(8'h11, 1); add(8'h22, 1); add(8'h33, 1); add(8'h44, 1);
    run_scenario("after_err", 1'b1);

    // One-cycle glitch while idle is rejected
    pulse_reset();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_done", 32'(load_done), 32'd0);
    chk("glitch_err", 32'(load_error), 32'd0);
    chk("glitch_hold", 32'(cpu_hold), 32'd1);
    add(8'h01, 1); add(8'h00, 1);
    add(8'hC3, 1); add(8'hB2, 1); add(8'hA1, 1); add(8'h90, 1);
    run_scenario("post_glitch", 1'b0);

    // Reset in the middle of a load
    pulse_reset();
    send_byte(8'h01, 1, 1); send_byte(8'h00, 1, 1);
    send_byte(8'hAA, 1, 1); send_byte(8'hBB, 1, 1);
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    add(8'h01, 1); add(8'h00, 1);
    add(8'h01, 1); add(8'h02, 1); add(8'h03, 1); add(8'h04, 1);
    run_scenario("resend", 1'b0);

    // Random images, with occasional framing errors and trailing bytes
    for (int k = 0; k < 8; k++) begin
      int n, nb;
      n  = int'($urandom_range(0, 5));
      nb = (n <= MAXW) ? 4 * n : int'($urandom_range(0, 8));
      add(8'(n), 1); add(8'h00, 1);
      for (int i = 0; i < nb; i++) add(8'($urandom), 1);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) add(8'($urandom), 1);
      if ($urandom_range(0, 3) == 0) sq[$urandom_range(0, bq.size() - 1)] = 1'b0;
      run_scenario($sformatf("random%0d", k), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Receiver side of the board's serial link, placed at the top level alongside the cpu.
- Receives an 8N1 UART byte stream on the RxD pin. Assembles little-endian 32-bit words and writes them into the memory's write port.
- Holds the cpu in reset while a program image is loaded. Releases it when the declared image length has been received.
- Makes memory contents loadable at run time instead of only at synthesis.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- NUM_OF_BYTES, 800, memory size in bytes; maximum loadable words = NUM_OF_BYTES/4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- RxD  input  1  asynchronous serial line; idle high.
- mem_address  output  32  byte address of current write; always word-aligned.
- mem_write_data  output  32  assembled word.
- mem_write_en  output  1  one-cycle write strobe.
- cpu_hold  output  1  high while loading; drives cpu reset.
- load_done  output  1  sticky; image fully written.
- load_error  output  1  sticky; framing error or oversize image.

Behaviour:
- Reset values:
  - mem_address=0, mem_write_data=0, mem_write_en=0.
  - cpu_hold=1, load_done=0, load_error=0.
  - RX FSM in RX_IDLE; loader FSM in L_CNT_LO.
- Input synchronisation: RxD passes through a 2-flop synchroniser (reset value 1) before any use. Add 2 cycles of latency.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE -> RX_START on a synchronised low.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then resample.
    - Still low -> RX_DATA.
    - High -> RX_IDLE (glitch rejected, no byte produced).
  - RX_DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first.
  - RX_STOP: sample one bit later.
    - High -> byte_valid pulses 1 cycle with the byte; return to RX_IDLE.
    - Low -> set load_error, discard the byte; return to RX_IDLE only after the line returns high.
- Loader FSM states: L_CNT_LO, L_CNT_HI, L_DATA, L_DONE, L_ERR.
  - L_CNT_LO: first byte = word count N[7:0].
  - L_CNT_HI: second byte = N[15:8].
    - N=0 -> L_DONE directly.
    - N > NUM_OF_BYTES/4 -> L_ERR.
    - Otherwise -> L_DATA.
  - L_DATA: bytes fill word bytes 0..3 (first received = bits[7:0]).
    - On the 4th byte, next cycle: mem_write_data=word, mem_address=4*index, mem_write_en=1 for exactly 1 cycle.
    - Word index increments after each write.
    - After write N -> L_DONE.
  - L_DONE: cpu_hold=0, load_done=1. All further bytes ignored.
  - L_ERR: cpu_hold stays 1, load_error=1. Bytes ignored. Only reset recovers.
- Framing error during L_DATA or count phase: transition to L_ERR. The partial word is never written.
- Byte latency: stop-bit sample to write strobe is ≤2 cycles. Addresses beyond NUM_OF_BYTES are never driven.
- Mid-load reset: asynchronously returns to reset values. The next byte is treated as N[7:0].
- Counters: bit counter 3 bits, baud counter ceil(log2(CLKS_PER_BIT)) bits, word index 16 bits. Baud counter reloads at every state entry.

Decomposition:
- Shared include file holds:
  - RX and loader state encodings.
  - Default CLKS_PER_BIT value.
  - The count-frame byte width (2).
- Sub-module uart_rx_byte: synchroniser plus RX FSM, outputting byte_valid, byte_data, frame_err.
- The top contains only the loader FSM and word assembly.

Test Plan (CLKS_PER_BIT=4, NUM_OF_BYTES=16):
- Send bytes 02 00 EF BE AD DE 78 56 34 12 -> two writes:
  - 0x00000000 <= 0xDEADBEEF
  - 0x00000004 <= 0x12345678
  - Each mem_write_en is 1 cycle wide; load_done=1 and cpu_hold=0 after the second write.
- Send 00 00 -> load_done=1 and cpu_hold=0 with no mem_write_en pulse. A following byte 55 is ignored.
- Send 05 00 (5 > 4 words) -> load_error=1, cpu_hold=1. Subsequent bytes produce no writes.
- Send 01 00 AA then a byte with stop bit low -> load_error=1 and no write occurs. Reset, then a valid 01 00 11 22 33 44 -> write 0x44332211 @0.
- 1-cycle low glitch on RxD while idle -> no byte, no state change. Then a valid image loads normally.
- Assert reset after 01 00 AA BB -> outputs return to reset values immediately. Resending 01 00 01 02 03 04 -> write 0x04030201 @0.
